elevator_request_scheduler: RTL and testbench
=============================================

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (0..NUM_FLOORS-1).
REQ-002 SHALL have parameter DOOR_TICKS, default 32'd20000000, clock cycles the door stays open.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port call_valid  input  1  one-cycle pulse: floor call present.
REQ-006 SHALL have port call_floor  input  4  floor number of the call.
REQ-007 SHALL have port current_floor  input  4  car position from the elevator state machine.
REQ-008 SHALL have port car_idle  input  1  high when the car is stopped.
REQ-009 SHALL have port target_floor  output  4  registered floor the car is sent to.
REQ-010 SHALL have port target_valid  output  1  high while target_floor is a live dispatch.
REQ-011 SHALL have port direction_up  output  1  current sweep direction, 1 = up.
REQ-012 SHALL have port door_open  output  1  high during door dwell.
REQ-013 SHALL have port pending  output  NUM_FLOORS  registered outstanding-call bitmask.

Function
REQ-014 SHALL set pending[call_floor] on any cycle with call_valid=1 and call_floor<NUM_FLOORS; calls with call_floor>=NUM_FLOORS SHALL be dropped without effect.
REQ-015 SHALL implement states IDLE, SELECT, TRAVEL, DOOR; all outputs registered.
REQ-016 IDLE: pending==0 -> stay; else -> SELECT next cycle.
REQ-017 SELECT (one cycle): if pending[current_floor] -> DOOR; else, if direction_up, pick lowest pending floor > current_floor; if none, invert direction_up and pick highest pending floor < current_floor; mirror rule when direction is down; load target_floor, assert target_valid, -> TRAVEL.
REQ-018 TRAVEL: stay until car_idle=1 and current_floor==target_floor; then deassert target_valid, clear pending[target_floor], -> DOOR.
REQ-019 TRAVEL: a new call on a floor strictly between current_floor and target_floor in the sweep direction SHALL retarget target_floor to it on the next cycle (SCAN pickup).
REQ-020 DOOR: door_open=1 for exactly DOOR_TICKS cycles, pending[current_floor] cleared on entry; then -> SELECT if pending!=0, else IDLE.
REQ-021 DOOR: a call for current_floor SHALL not set pending and SHALL restart the dwell count.
REQ-022 Same-cycle set and clear of the same bit: clear wins (floor is being served).
REQ-023 target_floor SHALL always be < NUM_FLOORS; direction_up SHALL only change in SELECT.
REQ-024 Latency: call while IDLE to target_valid rising = 2 cycles (IDLE->SELECT->TRAVEL).

Reset
REQ-025 Reset SHALL asynchronously force state IDLE, pending=0, target_floor=0, target_valid=0, direction_up=1, door_open=0, door counter=0.
REQ-026 Reset asserted mid-TRAVEL or mid-DOOR SHALL discard all pending calls; no output glitch beyond reset values.

Structure
REQ-027 Package elevator_pkg SHALL hold NUM_FLOORS default, state encoding constants and DOOR_TICKS default, shared with the elevator state machine and 7-segment display.
REQ-028 Door dwell counting SHALL be a sub-module door_timer (start/restart input, done pulse, DOOR_TICKS parameter).
REQ-029 Floor selection SHALL be combinational priority logic inside the block, width-parameterised by NUM_FLOORS.

Verification (DOOR_TICKS=4 in bench)
REQ-030 Reset, then call 5 at floor 0 -> target_valid after 2 cycles, target_floor=5, direction_up=1; car arrives idle at 5 -> door_open 4 cycles, pending=0, IDLE.
REQ-031 At floor 3 moving up to 8, call 6 -> target_floor becomes 6 next cycle; after 6 served, target 8.
REQ-032 At floor 5 idle, pending {2,7}, direction_up=1 -> 7 first, then direction_up=0, target 2.
REQ-033 Call 12 (NUM_FLOORS=10) -> pending unchanged, state unchanged.
REQ-034 In DOOR at floor 4, call 4 on tick 3 -> pending[4] stays 0, door_open held 4 further cycles.
REQ-035 Reset pulsed mid-TRAVEL with pending {1,9} -> all outputs at reset values immediately, IDLE after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Constants shared by the elevator slice: floor count, door dwell length,
// scheduler state encoding and the sweep-direction test used for pickups.
package elevator_pkg;

    localparam int          NUM_FLOORS_DEF = 10;
    localparam logic [31:0] DOOR_TICKS_DEF = 32'd20000000;
    localparam int          FLOOR_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_TRAVEL = 2'd2,
        ST_DOOR   = 2'd3
    } sched_state_e;

    // True when floor lies strictly between the car and its target in the sweep direction.
    function automatic logic strictly_ahead(
        input logic [FLOOR_W-1:0] floor,
        input logic [FLOOR_W-1:0] cur,
        input logic [FLOOR_W-1:0] tgt,
        input logic               up
    );
        return up ? ((floor > cur) && (floor < tgt))
                  : ((floor < cur) && (floor > tgt));
    endfunction

endpackage

// File: rtl/door_timer.sv
// Door dwell counter: start (or restart) loads the count, done pulses on the
// last cycle of the dwell so the door is open for exactly DOOR_TICKS cycles.
module door_timer
    import elevator_pkg::*;
#(
    parameter logic [31:0] DOOR_TICKS = DOOR_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic done_o
);

    localparam logic [31:0] LOAD = (DOOR_TICKS == 32'd0) ? 32'd0 : DOOR_TICKS - 32'd1;

    logic [31:0] count_q;
    logic        running_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start_i) begin
            count_q   <= LOAD;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (count_q == '0) begin
                running_q <= 1'b0;
            end else begin
                count_q <= count_q - 32'd1;
            end
        end
    end

    assign done_o = running_q && (count_q == '0);

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN elevator scheduler: latches floor calls, picks the next stop in the
// current sweep direction, picks up calls on the way and times the door dwell.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int          NUM_FLOORS = NUM_FLOORS_DEF,
    parameter logic [31:0] DOOR_TICKS = DOOR_TICKS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  direction_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    sched_state_e           state_q;
    logic [NUM_FLOORS-1:0]  pending_q;
    logic [NUM_FLOORS-1:0]  pending_d;
    logic [FLOOR_W-1:0]     target_floor_q;
    logic                   target_valid_q;
    logic                   direction_up_q;
    logic                   door_open_q;

    logic [NUM_FLOORS-1:0]  call_onehot;
    logic [NUM_FLOORS-1:0]  cur_onehot;
    logic [NUM_FLOORS-1:0]  tgt_onehot;
    logic [NUM_FLOORS-1:0]  above_mask;
    logic [NUM_FLOORS-1:0]  below_mask;
    logic [NUM_FLOORS-1:0]  set_mask;
    logic [NUM_FLOORS-1:0]  clr_mask;

    logic                   up_found;
    logic [FLOOR_W-1:0]     up_floor;
    logic                   dn_found;
    logic [FLOOR_W-1:0]     dn_floor;

    logic cur_pending;
    logic door_hit;
    logic arrive;
    logic select_door;
    logic retarget;
    logic timer_start;
    logic timer_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign call_onehot[gi] = (call_floor == FLOOR_W'(gi));
            assign cur_onehot[gi]  = (current_floor == FLOOR_W'(gi));
            assign tgt_onehot[gi]  = (target_floor_q == FLOOR_W'(gi));
            assign above_mask[gi]  = pending_q[gi] && (FLOOR_W'(gi) > current_floor);
            assign below_mask[gi]  = pending_q[gi] && (FLOOR_W'(gi) < current_floor);
        end
    endgenerate

    // Nearest pending floor above and below the car.
    always_comb begin
        up_found = 1'b0;
        up_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above_mask[i]) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        dn_found = 1'b0;
        dn_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (below_mask[i]) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

    assign cur_pending = |(pending_q & cur_onehot);
    assign door_hit    = call_valid && (state_q == ST_DOOR) && (|(call_onehot & cur_onehot));
    assign arrive      = (state_q == ST_TRAVEL) && car_idle && (current_floor == target_floor_q);
    assign select_door = (state_q == ST_SELECT) && cur_pending;
    assign retarget    = (state_q == ST_TRAVEL) && call_valid && (|call_onehot)
                         && strictly_ahead(call_floor, current_floor, target_floor_q, direction_up_q);
    assign timer_start = arrive || select_door || door_hit;

    // A floor being served wins over a call for it in the same cycle.
    assign set_mask  = (call_valid && !door_hit) ? call_onehot : '0;
    assign clr_mask  = (arrive ? tgt_onehot : '0) | (select_door ? cur_onehot : '0);
    assign pending_d = (pending_q | set_mask) & ~clr_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            target_floor_q <= '0;
            target_valid_q <= 1'b0;
            direction_up_q <= 1'b1;
            door_open_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    if (|pending_d) begin
                        state_q <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (cur_pending) begin
                        state_q     <= ST_DOOR;
                        door_open_q <= 1'b1;
                    end else if (up_found && (direction_up_q || !dn_found)) begin
                        target_floor_q <= up_floor;
                        direction_up_q <= 1'b1;
                        target_valid_q <= 1'b1;
                        state_q        <= ST_TRAVEL;
                    end else if (dn_found) begin
                        target_floor_q <= dn_floor;
                        direction_up_q <= 1'b0;
                        target_valid_q <= 1'b1;
                        state_q        <= ST_TRAVEL;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TRAVEL: begin
                    if (arrive) begin
                        target_valid_q <= 1'b0;
                        door_open_q    <= 1'b1;
                        state_q        <= ST_DOOR;
                    end else if (retarget) begin
                        target_floor_q <= call_floor;
                    end
                end
                ST_DOOR: begin
                    if (timer_done && !door_hit) begin
                        door_open_q <= 1'b0;
                        state_q     <= (|pending_d) ? ST_SELECT : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    door_timer #(
        .DOOR_TICKS (DOOR_TICKS)
    ) u_door_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (timer_start),
        .done_o  (timer_done)
    );

    assign target_floor = target_floor_q;
    assign target_valid = target_valid_q;
    assign direction_up = direction_up_q;
    assign door_open    = door_open_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Randomised and directed bench for the elevator scheduler: a SCAN service
// model predicts dispatches and door dwells, a monitor checks them in order.
`timescale 1ns/1ps
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int DT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          call_valid = 1'b0;
    logic [3:0]    call_floor = 4'd0;
    logic [3:0]    current_floor = 4'd0;
    logic          car_idle = 1'b1;
    logic [3:0]    target_floor;
    logic          target_valid;
    logic          direction_up;
    logic          door_open;
    logic [NF-1:0] pending;

    always #5 clk = ~clk;

    elevator_request_scheduler #(
        .NUM_FLOORS (NF),
        .DOOR_TICKS (32'(DT))
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .current_floor (current_floor),
        .car_idle      (car_idle),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .direction_up  (direction_up),
        .door_open     (door_open),
        .pending       (pending)
    );

    typedef struct {
        bit is_door;
        int floor;
        bit up;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: set of outstanding floors, car floor, sweep direction.
    bit   m_pend[NF];
    int   m_cur;
    bit   m_up;
    int   m_tgt;
    int   extra_q[$];
    int   gap_q[$];
    bit   car_move = 1'b0;
    bit   car_phase = 1'b0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endfunction

    function automatic void push_dispatch(int f, bit up);
        exp_t e;
        e.is_door = 1'b0; e.floor = f; e.up = up; e.len = 0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_door(int f, int len);
        exp_t e;
        e.is_door = 1'b1; e.floor = f; e.up = 1'b0; e.len = len;
        exp_q.push_back(e);
    endfunction

    function automatic bit model_any();
        for (int i = 0; i < NF; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Next stop: nearest outstanding floor ahead; if none, turn around.
    function automatic int model_pick();
        int ahead = -1;
        int behind = -1;
        for (int f = m_cur + 1; f < NF; f++) if (m_pend[f] && ahead < 0) ahead = f;
        for (int f = m_cur - 1; f >= 0; f--) if (m_pend[f] && behind < 0) behind = f;
        if (m_up) begin
            if (ahead >= 0) return ahead;
            m_up = 1'b0;
            return behind;
        end
        if (behind >= 0) return behind;
        m_up = 1'b1;
        return ahead;
    endfunction

    function automatic void model_drain();
        int t;
        while (model_any()) begin
            if (m_pend[m_cur]) begin
                push_door(m_cur, DT);
                m_pend[m_cur] = 1'b0;
            end else begin
                t = model_pick();
                push_dispatch(t, m_up);
                push_door(t, DT);
                m_pend[t] = 1'b0;
                m_cur = t;
            end
        end
    endfunction

    // One clock of stimulus; the car walks one floor every two cycles toward its target.
    task automatic step();
        @(negedge clk);
        if (car_move && target_valid && current_floor != target_floor) begin
            car_idle  = 1'b0;
            car_phase = ~car_phase;
            if (car_phase)
                current_floor = (target_floor > current_floor) ? current_floor + 4'd1
                                                               : current_floor - 4'd1;
        end else begin
            car_idle = 1'b1;
        end
    endtask

    task automatic wait_quiet(string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || door_open || target_valid) && cyc < 3000) begin
            step();
            cyc++;
        end
        check({name, " finished in budget"}, int'(cyc < 3000), 1);
        step();
        step();
        check({name, " pending after"}, int'(pending), 0);
        check({name, " target_valid after"}, int'(target_valid), 0);
        check({name, " door_open after"}, int'(door_open), 0);
    endtask

    task automatic run_batch(string name, int first, bit stop_in_travel);
        int g;
        m_cur = current_floor;
        m_pend[first] = 1'b1;
        m_tgt = model_pick();
        push_dispatch(m_tgt, m_up);
        call_valid = 1'b1; call_floor = 4'(first);
        step();
        call_valid = 1'b0;
        check({name, " target_valid in select"}, int'(target_valid), 0);
        step();
        check({name, " target_valid at latency 2"}, int'(target_valid), 1);
        foreach (extra_q[k]) begin
            g = extra_q[k];
            if (g < NF) begin
                m_pend[g] = 1'b1;
                if (m_up ? (g > m_cur && g < m_tgt) : (g < m_cur && g > m_tgt)) m_tgt = g;
            end
            call_valid = 1'b1; call_floor = 4'(g);
            step();
            call_valid = 1'b0;
            check({name, " target_floor after call"}, int'(target_floor), m_tgt);
            for (int j = 0; j < gap_q[k]; j++) step();
        end
        if (stop_in_travel) return;
        push_door(m_tgt, DT);
        m_pend[m_tgt] = 1'b0;
        m_cur = m_tgt;
        model_drain();
        car_move = 1'b1;
        wait_quiet(name);
        car_move = 1'b0;
    endtask

    // Monitor: pops one expectation per dispatch rise and per door opening.
    initial begin : monitor
        bit   tv_prev = 1'b0;
        bit   door_prev = 1'b0;
        int   door_len = 0;
        int   door_req = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                tv_prev = 1'b0; door_prev = 1'b0; door_len = 0;
            end else begin
                if (target_valid && !tv_prev) begin
                    check("dispatch has queued work", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("dispatch kind is door", int'(e.is_door), 0);
                        check("dispatch floor", int'(target_floor), e.floor);
                        check("dispatch direction_up", int'(direction_up), int'(e.up));
                    end
                end
                if (door_open) begin
                    if (!door_prev) begin
                        check("door has queued work", int'(exp_q.size() > 0), 1);
                        door_req = DT;
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("door kind is door", int'(e.is_door), 1);
                            check("door floor", int'(current_floor), e.floor);
                            door_req = e.len;
                        end
                        door_len = 0;
                    end
                    door_len++;
                    check("pending clear at open door", int'(pending[current_floor]), 0);
                end else if (door_prev) begin
                    check("door dwell cycles", door_len, door_req);
                end
                tv_prev   = target_valid;
                door_prev = door_open;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, want finish", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cyc;
        int first;
        int k;
        for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
        m_up = 1'b1;
        m_cur = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset target_floor", int'(target_floor), 0);
        check("reset target_valid", int'(target_valid), 0);
        check("reset direction_up", int'(direction_up), 1);
        check("reset door_open", int'(door_open), 0);
        check("reset pending", int'(pending), 0);
        reset = 1'b0;
        step();

        // Call 5 from floor 0.
        current_floor = 4'd0;
        extra_q.delete(); gap_q.delete();
        run_batch("call5", 5, 1'b0);

        // Heading 3 -> 8, a call at 6 is picked up on the way.
        current_floor = 4'd3;
        extra_q = '{6}; gap_q = '{0};
        run_batch("pickup6", 8, 1'b0);

        // From 5 going up with {7,2}: 7 first, then reverse to 2.
        current_floor = 4'd5;
        extra_q = '{2}; gap_q = '{1};
        run_batch("sweep72", 7, 1'b0);

        // Out-of-range call is ignored.
        call_valid = 1'b1; call_floor = 4'd12;
        step();
        call_valid = 1'b0;
        repeat (3) step();
        check("call12 pending", int'(pending), 0);
        check("call12 target_valid", int'(target_valid), 0);
        check("call12 door_open", int'(door_open), 0);

        // Door at 4, re-call of 4 on the third open cycle restarts the dwell.
        current_floor = 4'd4;
        m_cur = 4;
        push_door(4, DT + 3);
        call_valid = 1'b1; call_floor = 4'd4;
        step();
        call_valid = 1'b0;
        cyc = 0;
        while (!door_open && cyc < 10) begin
            step();
            cyc++;
        end
        check("recall4 door opened", int'(door_open), 1);
        step();
        step();
        call_valid = 1'b1; call_floor = 4'd4;
        step();
        call_valid = 1'b0;
        check("recall4 pending stays clear", int'(pending), 0);
        wait_quiet("recall4");

        // Reset in the middle of travel with {9,1} outstanding.
        current_floor = 4'd5;
        extra_q = '{1}; gap_q = '{1};
        run_batch("reset_travel", 9, 1'b1);
        check("reset_travel pending before", int'(pending), (1 << 9) | (1 << 1));
        #2;
        reset = 1'b1;
        #1;
        check("reset_travel target_valid", int'(target_valid), 0);
        check("reset_travel target_floor", int'(target_floor), 0);
        check("reset_travel direction_up", int'(direction_up), 1);
        check("reset_travel door_open", int'(door_open), 0);
        check("reset_travel pending", int'(pending), 0);
        exp_q.delete();
        for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
        m_up = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        check("reset_travel idle target_valid", int'(target_valid), 0);
        check("reset_travel idle pending", int'(pending), 0);

        // Random batches of calls from a quiet car.
        for (int b = 0; b < 25; b++) begin
            if ($urandom_range(0, 3) == 0) current_floor = 4'($urandom_range(0, NF - 1));
            first = $urandom_range(0, NF - 1);
            while (first == int'(current_floor)) first = $urandom_range(0, NF - 1);
            extra_q.delete(); gap_q.delete();
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) begin
                extra_q.push_back($urandom_range(0, 15));
                gap_q.push_back($urandom_range(0, 2));
            end
            $display("batch %0d: car %0d first call %0d, %0d more calls", b, current_floor, first, k);
            run_batch("random", first, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
